// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: refill FSM states
// and instruction-cache line geometry.
package pipeline_control_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_FILL = 2'd3
   } refill_state_e;

   // log2 of the 16-byte (128-bit) refill line
   localparam int LINE_OFFSET = 4;

endpackage

// File: rtl/pipeline_control_unit_hazard_detect.sv
// Load-use comparator: flags a decode instruction that reads the destination
// of a load still sitting in ID/EX. Purely combinational.
module hazard_detect
   import pipeline_control_unit_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             load_use
);

   // $zero is never a real dependency
   assign load_use = idex_memread && (idex_rt != '0) &&
                     ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: I-cache refill FSM, load-use
// stall, MEM-stage branch flush and saturating miss/stall counters.
module pipeline_control_unit
   import pipeline_control_unit_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int REG_W          = 5,
   parameter int REFILL_TIMEOUT = 255,
   parameter int CNT_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_hit,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   output logic              fill_en,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              idex_memread,
   input  logic [REG_W-1:0]  idex_rt,
   input  logic              exmem_pcsrc,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              exmem_flush,
   output logic              refill_busy,
   output logic              refill_err,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int                TMO_W     = $clog2(REFILL_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(REFILL_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET) - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   refill_state_e     state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              mem_req_q, mem_req_d;
   logic              fill_en_q, fill_en_d;
   logic              refill_err_q, refill_err_d;
   logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              load_use;
   logic              miss_stall;

   hazard_detect #(
      .REG_W(REG_W)
   ) u_hazard (
      .idex_memread(idex_memread),
      .idex_rt     (idex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .load_use    (load_use)
   );

   // The miss stall covers the detect cycle as well as every non-IDLE state
   assign miss_stall = (state_q != ST_IDLE) || !if_hit;

   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      if (rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (exmem_pcsrc) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         pc_write    = !(miss_stall || load_use);
         ifid_write  = !load_use;
         ifid_flush  = miss_stall && !load_use;
         idex_bubble = load_use;
      end
   end

   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      mem_req_d    = mem_req_q;
      fill_en_d    = 1'b0;
      refill_err_d = refill_err_q;
      miss_cnt_d   = miss_cnt_q;
      stall_cnt_d  = pc_write ? stall_cnt_q : sat_inc(stall_cnt_q);
      mem_addr_d   = mem_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (!if_hit) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = if_pc & LINE_MASK;
               miss_cnt_d = sat_inc(miss_cnt_q);
               tmo_d      = '0;
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d   = ST_WAIT;
               mem_req_d = 1'b0;
               tmo_d     = '0;
            end
         end
         ST_WAIT: begin
            // A returning line wins over a timeout in the same cycle
            if (mem_rvalid) begin
               state_d   = ST_FILL;
               fill_en_d = 1'b1;
               tmo_d     = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d      = ST_REQ;
               mem_req_d    = 1'b1;
               refill_err_d = 1'b1;
               tmo_d        = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_FILL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tmo_q        <= '0;
         mem_req_q    <= 1'b0;
         fill_en_q    <= 1'b0;
         refill_err_q <= 1'b0;
         miss_cnt_q   <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         mem_req_q    <= mem_req_d;
         fill_en_q    <= fill_en_d;
         refill_err_q <= refill_err_d;
         miss_cnt_q   <= miss_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   // Address is only meaningful while mem_req is up, so it carries no reset
   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign fill_en     = fill_en_q;
   assign refill_busy = (state_q != ST_IDLE);
   assign refill_err  = refill_err_q;
   assign miss_cnt    = miss_cnt_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: combinational hazard/branch vector
// table plus cycle-by-cycle refill sequences; a 2-bit-counter copy shows saturation.
module tb_pipeline_control_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_hit, mem_gnt, mem_rvalid, idex_memread, exmem_pcsrc;
   logic [31:0] if_pc;
   logic [4:0]  id_rs, id_rt, idex_rt;

   logic        mem_req, fill_en, pc_write, ifid_write, ifid_flush;
   logic        idex_bubble, exmem_flush, refill_busy, refill_err;
   logic [31:0] mem_addr, miss_cnt, stall_cnt;

   logic        s_mem_req, s_fill_en, s_pc_write, s_ifid_write, s_ifid_flush;
   logic        s_idex_bubble, s_exmem_flush, s_refill_busy, s_refill_err;
   logic [31:0] s_mem_addr;
   logic [1:0]  s_miss_cnt, s_stall_cnt;

   pipeline_control_unit #(
      .ADDR_W(32), .REG_W(5), .REFILL_TIMEOUT(4), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .if_hit(if_hit), .if_pc(if_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .fill_en(fill_en),
      .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .exmem_pcsrc(exmem_pcsrc), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
      .refill_busy(refill_busy), .refill_err(refill_err),
      .miss_cnt(miss_cnt), .stall_cnt(stall_cnt)
   );

   pipeline_control_unit #(
      .ADDR_W(32), .REG_W(5), .REFILL_TIMEOUT(4), .CNT_W(2)
   ) u_sat (
      .clk(clk), .rst(rst), .if_hit(if_hit), .if_pc(if_pc),
      .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .fill_en(s_fill_en),
      .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .exmem_pcsrc(exmem_pcsrc), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
      .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
      .refill_busy(s_refill_busy), .refill_err(s_refill_err),
      .miss_cnt(s_miss_cnt), .stall_cnt(s_stall_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string nm, input logic pw, input logic iw,
                          input logic fl, input logic bb, input logic ef);
      chk({nm, " pc_write"}, pc_write, pw);
      chk({nm, " ifid_write"}, ifid_write, iw);
      chk({nm, " ifid_flush"}, ifid_flush, fl);
      chk({nm, " idex_bubble"}, idex_bubble, bb);
      chk({nm, " exmem_flush"}, exmem_flush, ef);
   endtask

   typedef struct {
      logic       mr;
      logic [4:0] xrt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       br;
      logic       pw, iw, fl, bb, ef;
   } vec_t;

   vec_t vecs[9];
   int   exp_stall;
   int   fills;

   initial begin
      vecs[0] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 5'd8,  5'd8, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 5'd8,  5'd0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 5'd8,  5'd8, 5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 5'd8,  5'd9, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 5'd8,  5'd8, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 5'd31, 5'd3, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; if_hit = 1'b1; if_pc = 32'h0040_0000;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; exmem_pcsrc = 1'b0;
      idex_memread = 1'b0; idex_rt = '0; id_rs = '0; id_rt = '0;

      // Reset state
      #1;
      chk("rst pc_write", pc_write, 1'b0);
      chk("rst ifid_write", ifid_write, 1'b0);
      chk("rst busy", refill_busy, 1'b0);
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst fill_en", fill_en, 1'b0);
      chk("rst err", refill_err, 1'b0);
      chk("rst miss_cnt", miss_cnt, 32'd0);
      chk("rst stall_cnt", stall_cnt, 32'd0);
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // Load-use / branch vector table with the cache hitting
      exp_stall = 0;
      for (int i = 0; i < 9; i++) begin
         idex_memread = vecs[i].mr; idex_rt = vecs[i].xrt;
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; exmem_pcsrc = vecs[i].br;
         #1;
         chk_ctl($sformatf("vec%0d", i), vecs[i].pw, vecs[i].iw, vecs[i].fl,
                 vecs[i].bb, vecs[i].ef);
         if (!vecs[i].pw) exp_stall++;
         cyc();
      end
      idex_memread = 1'b0; idex_rt = '0; id_rs = '0; id_rt = '0; exmem_pcsrc = 1'b0;
      #1;
      chk("vec stall_cnt", stall_cnt, 32'(exp_stall));
      chk("vec miss_cnt", miss_cnt, 32'd0);
      chk("vec busy", refill_busy, 1'b0);
      cyc();

      // Reset in the middle of WAIT with a line arriving
      if_pc = 32'h0040_0040; if_hit = 1'b0;
      cyc();
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      #1;
      chk("rwait busy before", refill_busy, 1'b1);
      mem_rvalid = 1'b1; rst = 1'b1;
      #1;
      chk("rwait busy", refill_busy, 1'b0);
      chk("rwait mem_req", mem_req, 1'b0);
      chk("rwait miss_cnt", miss_cnt, 32'd0);
      chk("rwait stall_cnt", stall_cnt, 32'd0);
      chk("rwait pc_write", pc_write, 1'b0);
      cyc();
      rst = 1'b0; mem_rvalid = 1'b0; if_hit = 1'b1;
      #1;
      chk("rwait after busy", refill_busy, 1'b0);
      chk("rwait after fill_en", fill_en, 1'b0);
      chk("rwait after pc_write", pc_write, 1'b1);
      cyc();

      // Basic miss: grant next cycle, line two cycles after that
      fills = 0;
      if_pc = 32'h0040_0014; if_hit = 1'b0;
      #1;
      chk_ctl("miss c0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("miss c0 busy", refill_busy, 1'b0);
      cyc();
      mem_gnt = 1'b1;
      #1;
      chk("miss c1 mem_req", mem_req, 1'b1);
      chk("miss c1 mem_addr", mem_addr, 32'h0040_0010);
      chk("miss c1 miss_cnt", miss_cnt, 32'd1);
      chk("miss c1 busy", refill_busy, 1'b1);
      chk_ctl("miss c1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (fill_en) fills++;
      cyc();
      mem_gnt = 1'b0;
      #1;
      chk("miss c2 mem_req", mem_req, 1'b0);
      if (fill_en) fills++;
      cyc();
      mem_rvalid = 1'b1;
      #1;
      if (fill_en) fills++;
      cyc();
      mem_rvalid = 1'b0; if_hit = 1'b1;
      #1;
      chk("miss c4 fill_en", fill_en, 1'b1);
      chk("miss c4 pc_write", pc_write, 1'b0);
      if (fill_en) fills++;
      cyc();
      #1;
      if (fill_en) fills++;
      chk("miss fill pulses", 32'(fills), 32'd1);
      chk("miss c5 busy", refill_busy, 1'b0);
      chk("miss c5 pc_write", pc_write, 1'b1);
      chk("miss stall_cnt", stall_cnt, 32'd5);
      chk("miss miss_cnt", miss_cnt, 32'd1);
      cyc();

      // Timeout: rvalid withheld for four WAIT cycles, then a retry completes
      if_pc = 32'h0040_0100; if_hit = 1'b0;
      cyc();
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("tmo wait%0d err", i), refill_err, 1'b0);
         chk($sformatf("tmo wait%0d mem_req", i), mem_req, 1'b0);
         cyc();
      end
      #1;
      chk("tmo err", refill_err, 1'b1);
      chk("tmo reissue mem_req", mem_req, 1'b1);
      chk("tmo retry addr", mem_addr, 32'h0040_0100);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      #1;
      chk("tmo retry wait mem_req", mem_req, 1'b0);
      cyc();
      mem_rvalid = 1'b0; if_hit = 1'b1;
      #1;
      chk("tmo fill_en", fill_en, 1'b1);
      cyc();
      #1;
      chk("tmo done busy", refill_busy, 1'b0);
      chk("tmo err sticky", refill_err, 1'b1);
      chk("tmo miss_cnt", miss_cnt, 32'd2);
      chk("tmo stall_cnt", stall_cnt, 32'd14);
      cyc();

      // Branch during WAIT, then load-use while the line arrives
      if_pc = 32'h0040_0200; if_hit = 1'b0;
      cyc();
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0; exmem_pcsrc = 1'b1;
      idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
      #1;
      chk_ctl("brwait", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc();
      exmem_pcsrc = 1'b0; mem_rvalid = 1'b1;
      #1;
      chk_ctl("luwait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("luwait busy", refill_busy, 1'b1);
      cyc();
      mem_rvalid = 1'b0; idex_memread = 1'b0; idex_rt = '0; id_rs = '0; if_hit = 1'b1;
      #1;
      chk("brwait fill_en", fill_en, 1'b1);
      cyc();
      #1;
      chk("brwait idle", refill_busy, 1'b0);
      chk("brwait fill_en off", fill_en, 1'b0);
      chk("final miss_cnt", miss_cnt, 32'd3);
      chk("final stall_cnt", stall_cnt, 32'd18);
      chk("sat stall_cnt", s_stall_cnt, 2'd3);
      chk("sat miss_cnt", s_miss_cnt, 2'd3);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
